// File: rtl/data_memory_unit.sv
// data_memory_unit: multi-cycle 64-bit little-endian data memory for the MEM stage.
// Requests arrive behind a valid/ready handshake. A one-cycle response strobe
// carries the load data, or a fault when the upstream checker rejected the address.
// Optional feature: define DMU_BYTE_STRB_EN to add a per-byte store strobe port (write_strb).

module data_memory_unit #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DATA_W    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [63:0]         address,
    input  logic [DATA_W-1:0]   write_data,
`ifdef DMU_BYTE_STRB_EN
    input  logic [DATA_W/8-1:0] write_strb,
`endif
    input  logic                invMemAddr,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   read_data,
    output logic                fault,
    output logic                busy
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned IdxW     = $clog2(MEM_BYTES);
    localparam int unsigned CntW     = 4;

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateType;

    stateType            state;
    logic [CntW-1:0]     counter;
    logic                capRead;
    logic                capWrite;
    logic [IdxW-1:0]     capIdx;
    logic [DATA_W-1:0]   capData;
    logic [NumBytes-1:0] capStrb;

    // Storage is deliberately never reset.
    logic [7:0]          mem [MEM_BYTES];

    logic [IdxW-1:0]     reqIdx;
    logic [IdxW-1:0]     accIdx;
    logic [DATA_W-1:0]   accData;
    logic [DATA_W-1:0]   rdWord;
    logic [NumBytes-1:0] reqStrb;
    logic [NumBytes-1:0] accStrb;
    logic                memWe;

    // Byte index of (base + k) wrapped into the array; base is already < MEM_BYTES.
    function automatic logic [IdxW-1:0] wrapIdx(input logic [IdxW-1:0] base,
                                                input int unsigned k);
        logic [IdxW:0] sum;
        sum = {1'b0, base} + (IdxW+1)'(k);
        if (sum >= (IdxW+1)'(MEM_BYTES)) begin
            sum = sum - (IdxW+1)'(MEM_BYTES);
        end
        return sum[IdxW-1:0];
    endfunction

    assign reqIdx = IdxW'(address % 64'(MEM_BYTES));

`ifdef DMU_BYTE_STRB_EN
    assign reqStrb = write_strb;
`else
    assign reqStrb = '1;
`endif

    // Select the operands of the access happening at the next edge: captured ones
    // when leaving WAIT, live ones when a zero-latency request is accepted.
    always_comb begin
        accIdx  = capIdx;
        accData = capData;
        accStrb = capStrb;
        memWe   = (state == StWait) && (counter == '0) && capWrite;
        if (LATENCY == 0 && state == StIdle && req_valid && !invMemAddr) begin
            accIdx  = reqIdx;
            accData = write_data;
            accStrb = reqStrb;
            memWe   = MemWrite;
        end
    end

    // Gather the old contents of the addressed bytes, little-endian.
    always_comb begin
        rdWord = '0;
        for (int unsigned k = 0; k < NumBytes; k++) begin
            rdWord[8*k +: 8] = mem[wrapIdx(accIdx, k)];
        end
    end

    // Store the enabled bytes; the read above sees pre-store contents.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int unsigned k = 0; k < NumBytes; k++) begin
                if (accStrb[k]) begin
                    mem[wrapIdx(accIdx, k)] <= accData[8*k +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            counter    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            read_data  <= '0;
            fault      <= 1'b0;
            busy       <= 1'b0;
            capRead    <= 1'b0;
            capWrite   <= 1'b0;
            capIdx     <= '0;
            capData    <= '0;
            capStrb    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        capRead   <= MemRead;
                        capWrite  <= MemWrite;
                        capIdx    <= reqIdx;
                        capData   <= write_data;
                        capStrb   <= reqStrb;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (invMemAddr) begin
                            // Rejected address: respond at once, touch nothing.
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            fault      <= 1'b1;
                            read_data  <= '0;
                        end else if (!MemRead && !MemWrite) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            read_data  <= '0;
                        end else if (LATENCY == 0) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            read_data  <= MemRead ? rdWord : '0;
                        end else begin
                            state   <= StWait;
                            counter <= CntW'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (counter == '0) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                        read_data  <= capRead ? rdWord : '0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    resp_valid <= 1'b0;
                    read_data  <= '0;
                    fault      <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= StIdle;
                    resp_valid <= 1'b0;
                    read_data  <= '0;
                    fault      <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: byte-array transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.

module tb_data_memory_unit;

    localparam int unsigned MemBytes = 1024;
    localparam int unsigned Lat      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [63:0] address = '0;
    logic [63:0] write_data = '0;
`ifdef DMU_BYTE_STRB_EN
    logic [7:0]  write_strb = 8'hFF;
`endif
    logic        invMemAddr = 1'b0;
    logic        resp_valid;
    logic [63:0] read_data;
    logic        fault;
    logic        busy;

    data_memory_unit #(
        .MEM_BYTES(MemBytes),
        .LATENCY  (Lat),
        .DATA_W   (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .address   (address),
        .write_data(write_data),
`ifdef DMU_BYTE_STRB_EN
        .write_strb(write_strb),
`endif
        .invMemAddr(invMemAddr),
        .resp_valid(resp_valid),
        .read_data (read_data),
        .fault     (fault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: byte array plus the edge numbers of accept and response.
    logic [7:0]  mdlMem [MemBytes];
    int          cyc = 0;
    int          accEdge = -10;
    int          respEdge = -10;
    int          accCount = 0;
    bit          pend = 1'b0;
    bit          pRd, pWr, pInv;
    int          pIdx;
    logic [63:0] pWd;
    logic [7:0]  pStrb;
    logic [63:0] expData = '0;
    bit          expFault = 1'b0;

    task automatic modelAccess();
        expFault = pInv;
        expData  = '0;
        if (!pInv) begin
            if (pRd) begin
                for (int k = 0; k < 8; k++) expData[8*k +: 8] = mdlMem[(pIdx + k) % MemBytes];
            end
            if (pWr) begin
                for (int k = 0; k < 8; k++) begin
                    if (pStrb[k]) mdlMem[(pIdx + k) % MemBytes] = pWd[8*k +: 8];
                end
            end
        end
    endtask

    // Model update on each edge, then compare all outputs just after it.
    initial begin
        bit          eResp, eBusy;
        logic [63:0] eData;
        bit          eFault;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                accEdge  = -10;
                respEdge = -10;
                pend     = 1'b0;
            end else begin
                cyc++;
                if (!pend && cyc >= respEdge + 2 && req_valid === 1'b1) begin
                    pRd  = MemRead;
                    pWr  = MemWrite;
                    pInv = invMemAddr;
                    pIdx = int'(address % 64'(MemBytes));
                    pWd  = write_data;
`ifdef DMU_BYTE_STRB_EN
                    pStrb = write_strb;
`else
                    pStrb = 8'hFF;
`endif
                    accEdge  = cyc;
                    respEdge = cyc + ((pInv || (!pRd && !pWr)) ? 0 : int'(Lat));
                    pend     = 1'b1;
                    accCount++;
                end
                if (pend && cyc == respEdge) begin
                    modelAccess();
                    pend = 1'b0;
                end
            end
            #1;
            eResp  = (cyc == respEdge);
            eBusy  = (cyc >= accEdge) && (cyc <= respEdge);
            eData  = eResp ? expData : 64'h0;
            eFault = eResp ? expFault : 1'b0;
            tests++;
            if ({req_ready, busy, resp_valid, fault, read_data} !==
                {!eBusy, eBusy, eResp, eFault, eData}) begin
                fails++;
                $display("FAIL cycle_check @%0d: ready/busy/resp/fault=%b%b%b%b data=%h, want %b%b%b%b data=%h",
                         cyc, req_ready, busy, resp_valid, fault, read_data,
                         !eBusy, eBusy, eResp, eFault, eData);
            end
        end
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, return response and latency.
    task automatic doReq(input bit rd, input bit wr, input bit inv, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] strb,
                         output logic [63:0] rdata, output logic flt, output int lat);
        int startAcc;
        int n;
        rdata = '0;
        flt   = 1'b0;
        lat   = 0;
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        invMemAddr = inv;
        address    = addr;
        write_data = wd;
`ifdef DMU_BYTE_STRB_EN
        write_strb = strb;
`endif
        req_valid  = 1'b1;
        startAcc   = accCount;
        n = 0;
        while (accCount == startAcc && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid  = 1'b0;
        MemRead    = !rd;
        MemWrite   = !wr;
        invMemAddr = !inv;
        address    = ~addr;
        write_data = ~wd;
`ifdef DMU_BYTE_STRB_EN
        write_strb = ~strb;
`endif
        if (accCount == startAcc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept want accept within 40 cycles");
            return;
        end
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = read_data;
        flt   = fault;
        if (resp_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got no resp_valid want resp_valid within 40 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        fl;
        int          lt;
        int          startAcc;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        chkInt("reset_flags", int'({req_ready, busy, resp_valid, fault}), 8);
        chk64("reset_data", read_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload every byte with a known pattern.
        for (int i = 0; i < 128; i++) begin
            doReq(1'b0, 1'b1, 1'b0, 64'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF,
                  rd, fl, lt);
            if (i == 0) chkInt("preload_store_latency", lt, 3);
        end

        // Reset in the middle of a store's wait phase aborts it.
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; invMemAddr = 1'b0;
        address = 64'h40; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DMU_BYTE_STRB_EN
        write_strb = 8'hFF;
`endif
        req_valid = 1'b1;
        startAcc = accCount;
        n = 0;
        while (accCount == startAcc && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        chkInt("abort_store_accepted", accCount - startAcc, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chkInt("abort_reset_flags", int'({req_ready, busy, resp_valid, fault}), 8);
        chk64("abort_reset_data", read_data, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        doReq(1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 8'hFF, rd, fl, lt);
        chk64("abort_load_0x40", rd, 64'hC0DE_0000_0000_0008);

        // Store then load with the nominal latency.
        doReq(1'b0, 1'b1, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 8'hFF, rd, fl, lt);
        chkInt("store_latency", lt, 3);
        chk64("store_read_data_zero", rd, 64'h0);
        doReq(1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 8'hFF, rd, fl, lt);
        chkInt("load_latency", lt, 3);
        chk64("load_0x10", rd, 64'h1122_3344_5566_7788);
        doReq(1'b1, 1'b0, 1'b0, 64'hFFFF_0000_0000_0010, 64'h0, 8'hFF, rd, fl, lt);
        chk64("load_high_addr_bits", rd, 64'h1122_3344_5566_7788);

        // Checker fault: immediate response, no memory effect.
        doReq(1'b1, 1'b0, 1'b1, 64'h800, 64'h0, 8'hFF, rd, fl, lt);
        chkInt("fault_latency", lt, 1);
        chkInt("fault_flag", int'(fl), 1);
        chk64("fault_data", rd, 64'h0);
        doReq(1'b0, 1'b1, 1'b1, 64'h800, 64'hDEAD, 8'hFF, rd, fl, lt);
        chkInt("fault_store_flag", int'(fl), 1);
        doReq(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'hFF, rd, fl, lt);
        chk64("fault_array_unchanged", rd, 64'hC0DE_0000_0000_0000);

        // No-op request.
        doReq(1'b0, 1'b0, 1'b0, 64'h18, 64'h1234, 8'hFF, rd, fl, lt);
        chkInt("noop_latency", lt, 1);
        chkInt("noop_fault", int'(fl), 0);

        // Access wrapping past the top of the array.
        doReq(1'b0, 1'b1, 1'b0, 64'h3FC, 64'hAABB_CCDD_EEFF_0011, 8'hFF, rd, fl, lt);
        doReq(1'b1, 1'b0, 1'b0, 64'h3FC, 64'h0, 8'hFF, rd, fl, lt);
        chk64("wrap_load_0x3fc", rd, 64'hAABB_CCDD_EEFF_0011);
        doReq(1'b1, 1'b0, 1'b0, 64'h3F8, 64'h0, 8'hFF, rd, fl, lt);
        chk64("wrap_load_0x3f8", rd, 64'hEEFF_0011_0000_007F);
        doReq(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'hFF, rd, fl, lt);
        chk64("wrap_load_0x000", rd, 64'hC0DE_0000_AABB_CCDD);
        chkInt("model_byte_3fc", int'(mdlMem[1020]), 'h11);
        chkInt("model_byte_3ff", int'(mdlMem[1023]), 'hEE);
        chkInt("model_byte_003", int'(mdlMem[3]), 'hAA);

        // Read-before-write.
        doReq(1'b0, 1'b1, 1'b0, 64'h08, 64'h5, 8'hFF, rd, fl, lt);
        doReq(1'b1, 1'b1, 1'b0, 64'h08, 64'h9, 8'hFF, rd, fl, lt);
        chk64("rmw_old_value", rd, 64'h5);
        doReq(1'b1, 1'b0, 1'b0, 64'h08, 64'h0, 8'hFF, rd, fl, lt);
        chk64("rmw_new_value", rd, 64'h9);

        // Partial store via byte strobes (full store when the strobe port is absent).
        doReq(1'b0, 1'b1, 1'b0, 64'h20, 64'h0, 8'hFF, rd, fl, lt);
        doReq(1'b0, 1'b1, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, fl, lt);
        doReq(1'b1, 1'b0, 1'b0, 64'h20, 64'h0, 8'hFF, rd, fl, lt);
`ifdef DMU_BYTE_STRB_EN
        chk64("strobe_load_0x20", rd, 64'h0000_0000_FFFF_FFFF);
`else
        chk64("strobe_load_0x20", rd, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        // Randomized traffic: inputs change every cycle, occasional resets.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 299) != 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            MemRead    = 1'($urandom_range(0, 1));
            MemWrite   = 1'($urandom_range(0, 1));
            invMemAddr = ($urandom_range(0, 7) == 0);
            address    = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                address = 64'(1024 * $urandom_range(0, 100) + $urandom_range(1016, 1023));
            end
            write_data = {$urandom(), $urandom()};
`ifdef DMU_BYTE_STRB_EN
            write_strb = 8'($urandom());
`endif
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
